freelist_ctrl: RTL and testbench

R10K-style physical-register free-list manager and allocation arbiter.
- Shares the pool of unmapped physical registers among N dispatch slots, granting in age order (slot N-1 oldest).
- Accepts up to N Told returns per cycle from retire.
- On branch recovery (BPRecoverEN), restores the list to its precise, all-retired state in one cycle.
- Sits between dispatch/rename and retire.

---
 rtl/freelist_ctrl_pkg.sv | 20 ++
 rtl/freelist_ctrl_grant_chain.sv | 28 ++
 rtl/freelist_ctrl.sv | 79 +++++++
 tb/tb_freelist_ctrl.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/freelist_ctrl_pkg.sv
// freelist_ctrl_pkg: default sizing, tag/pointer types and modular pointer helper
// shared by the free-list manager and its bench.
package freelist_ctrl_pkg;
    localparam int DEF_N     = 3;
    localparam int DEF_ARCH  = 32;
    localparam int DEF_PHYS  = 64;
    localparam int DEF_FL_SZ = DEF_PHYS - DEF_ARCH;
    localparam int DEF_PRW   = $clog2(DEF_PHYS);
    localparam int DEF_PTRW  = $clog2(DEF_FL_SZ);
    localparam int DEF_CNTW  = $clog2(DEF_FL_SZ + 1);

    typedef logic [DEF_PRW-1:0]  phys_tag_t;
    typedef logic [DEF_PTRW-1:0] fl_ptr_t;
    typedef logic [DEF_CNTW-1:0] fl_cnt_t;

    // Operands never exceed 2*sz-1, so a single conditional subtract is a full modulo.
    function automatic int fl_wrap(input int s, input int sz);
        return (s >= sz) ? s - sz : s;
    endfunction
endpackage

// File: rtl/freelist_ctrl_grant_chain.sv
// fl_grant_chain: oldest-first (slot N-1 first) grant chain; each granted slot gets
// its rank among grants as an offset, and grants stop once i_limit are handed out.
module fl_grant_chain #(
    parameter int N    = 3,
    parameter int CNTW = 6
)(
    input  logic [N-1:0]           i_req,
    input  logic [CNTW-1:0]        i_limit,
    output logic [N-1:0]           o_gnt,
    output logic [N-1:0][CNTW-1:0] o_off,
    output logic [CNTW-1:0]        o_total
);
    logic [CNTW-1:0] w_k;

    always_comb begin
        w_k   = '0;
        o_gnt = '0;
        o_off = '0;
        for (int w = N - 1; w >= 0; w--) begin
            if (i_req[w] && w_k < i_limit) begin
                o_gnt[w] = 1'b1;
                o_off[w] = w_k;
                w_k      = w_k + CNTW'(1);
            end
        end
        o_total = w_k;
    end
endmodule

// File: rtl/freelist_ctrl.sv
// freelist_ctrl: R10K-style physical register free list; age-ordered allocation,
// multi-slot Told returns and single-cycle restore on branch recovery.
module freelist_ctrl
    import freelist_ctrl_pkg::*;
#(
    parameter  int N          = DEF_N,
    parameter  int ARCH_COUNT = DEF_ARCH,
    parameter  int PHYS_REGS  = DEF_PHYS,
    localparam int FL_SZ      = PHYS_REGS - ARCH_COUNT,
    localparam int PRW        = $clog2(PHYS_REGS),
    localparam int PTRW       = $clog2(FL_SZ),
    localparam int CNTW       = $clog2(FL_SZ + 1)
)(
    input  logic                   clock,
    input  logic                   reset,
    input  logic [N-1:0]           alloc_req,
    output logic [N-1:0]           alloc_gnt,
    output logic [N-1:0][PRW-1:0]  alloc_reg,
    output logic [CNTW-1:0]        free_count,
    input  logic [N-1:0]           FL_RetireEN,
    input  logic [N-1:0][PRW-1:0]  FL_RetireReg,
    input  logic                   BPRecoverEN,
    output logic                   fl_overflow_err
);
    logic [PRW-1:0]         r_fl [FL_SZ];
    logic [PTRW-1:0]        r_head, r_tail;
    logic [CNTW-1:0]        r_count;
    logic                   r_err;
    logic [N-1:0]           w_req, w_ren;
    logic [N-1:0][CNTW-1:0] w_goff, w_roff;
    logic [CNTW-1:0]        w_gtot, w_rtot, w_space, w_racc;
    logic                   w_ovf;

    assign w_req = alloc_req & {N{~BPRecoverEN}};

    fl_grant_chain #(.N(N), .CNTW(CNTW)) u_alloc (
        .i_req(w_req), .i_limit(r_count), .o_gnt(alloc_gnt), .o_off(w_goff), .o_total(w_gtot)
    );

    fl_grant_chain #(.N(N), .CNTW(CNTW)) u_ret (
        .i_req(FL_RetireEN), .i_limit(CNTW'(N)), .o_gnt(w_ren), .o_off(w_roff), .o_total(w_rtot)
    );

    // Room left after this cycle's grants; returns beyond it are dropped and flagged.
    assign w_space = CNTW'(FL_SZ - int'(r_count) + int'(w_gtot));
    assign w_ovf   = w_rtot > w_space;
    assign w_racc  = w_ovf ? w_space : w_rtot;

    always_comb begin
        alloc_reg = '0;
        for (int w = 0; w < N; w++)
            alloc_reg[w] = alloc_gnt[w] ? r_fl[PTRW'(fl_wrap(int'(r_head) + int'(w_goff[w]), FL_SZ))] : '0;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < FL_SZ; i++)
                r_fl[i] <= PRW'(ARCH_COUNT + i);
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= CNTW'(FL_SZ);
            r_err   <= 1'b0;
        end else if (BPRecoverEN) begin
            r_head  <= r_tail;
            r_count <= CNTW'(FL_SZ);
        end else begin
            r_head  <= PTRW'(fl_wrap(int'(r_head) + int'(w_gtot), FL_SZ));
            r_tail  <= PTRW'(fl_wrap(int'(r_tail) + int'(w_racc), FL_SZ));
            r_count <= r_count - w_gtot + w_racc;
            r_err   <= r_err | w_ovf;
            for (int w = 0; w < N; w++)
                if (w_ren[w] && w_roff[w] < w_space)
                    r_fl[PTRW'(fl_wrap(int'(r_tail) + int'(w_roff[w]), FL_SZ))] <= FL_RetireReg[w];
        end
    end

    assign free_count      = r_count;
    assign fl_overflow_err = r_err;
endmodule

// File: tb/tb_freelist_ctrl.sv
// tb_freelist_ctrl: directed vectors with hand-computed tags and counts for
// freelist_ctrl (N=3, 64 physical / 32 architectural registers).
module tb_freelist_ctrl;
    import freelist_ctrl_pkg::*;

    localparam int N = DEF_N;

    logic                     clock = 1'b0;
    logic                     reset;
    logic [N-1:0]             alloc_req;
    logic [N-1:0]             alloc_gnt;
    logic [N-1:0][DEF_PRW-1:0] alloc_reg;
    logic [DEF_CNTW-1:0]      free_count;
    logic [N-1:0]             FL_RetireEN;
    logic [N-1:0][DEF_PRW-1:0] FL_RetireReg;
    logic                     BPRecoverEN;
    logic                     fl_overflow_err;
    int                       n_chk = 0;
    int                       n_pass = 0;

    freelist_ctrl dut (
        .clock(clock), .reset(reset), .alloc_req(alloc_req), .alloc_gnt(alloc_gnt),
        .alloc_reg(alloc_reg), .free_count(free_count), .FL_RetireEN(FL_RetireEN),
        .FL_RetireReg(FL_RetireReg), .BPRecoverEN(BPRecoverEN), .fl_overflow_err(fl_overflow_err)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic step;
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic [2:0] req, input logic [2:0] ren, input logic [5:0] t2,
                         input logic [5:0] t1, input logic [5:0] t0, input logic bp);
        alloc_req    = req;
        FL_RetireEN  = ren;
        FL_RetireReg = {t2, t1, t0};
        BPRecoverEN  = bp;
        #1;
    endtask

    task automatic chk_gnt(input string tag, input logic [2:0] g, input logic [5:0] r2,
                           input logic [5:0] r1, input logic [5:0] r0);
        check({tag, ".gnt"}, 32'(alloc_gnt), 32'(g));
        check({tag, ".reg2"}, 32'(alloc_reg[2]), 32'(r2));
        check({tag, ".reg1"}, 32'(alloc_reg[1]), 32'(r1));
        check({tag, ".reg0"}, 32'(alloc_reg[0]), 32'(r0));
    endtask

    task automatic chk_cnt(input string tag, input int exp);
        check(tag, 32'(free_count), 32'(exp));
    endtask

    initial begin
        reset = 1'b0;
        alloc_req = '0;
        FL_RetireEN = '0;
        FL_RetireReg = '0;
        BPRecoverEN = 1'b0;
        #12;
        chk_cnt("rst.count", 32);
        check("rst.err", 32'(fl_overflow_err), 32'd0);
        check("rst.gnt", 32'(alloc_gnt), 32'd0);
        reset = 1'b1;
        step;
        // basic three-wide allocation from the reset list
        drive(3'b111, 3'b000, 0, 0, 0, 0);
        chk_gnt("t1", 3'b111, 32, 33, 34);
        step;
        chk_cnt("t1.count", 29);
        // drain to count=1; a lone younger request is still served
        for (int c = 0; c < 9; c++) begin
            drive(3'b111, 3'b000, 0, 0, 0, 0);
            step;
        end
        drive(3'b001, 3'b000, 0, 0, 0, 0);
        chk_gnt("t2.young", 3'b001, 0, 0, 62);
        step;
        chk_cnt("t2.count1", 1);
        drive(3'b111, 3'b000, 0, 0, 0, 0);
        chk_gnt("t2.last", 3'b100, 63, 0, 0);
        step;
        chk_cnt("t2.count0", 0);
        drive(3'b111, 3'b000, 0, 0, 0, 0);
        check("t2.empty", 32'(alloc_gnt), 32'd0);
        // returns are not bypassed to same-cycle grants
        drive(3'b111, 3'b101, 40, 0, 41, 0);
        check("t3.nobypass", 32'(alloc_gnt), 32'd0);
        step;
        chk_cnt("t3.count", 2);
        drive(3'b111, 3'b000, 0, 0, 0, 0);
        chk_gnt("t3.ret", 3'b110, 40, 41, 0);
        step;
        chk_cnt("t3.count0", 0);
        // refill fl[2..31]=1..30 and fl[0]=31, then walk head to 30
        for (int c = 0; c < 10; c++) begin
            drive(3'b000, 3'b111, 6'(3 * c + 1), 6'(3 * c + 2), 6'(3 * c + 3), 0);
            step;
        end
        drive(3'b000, 3'b100, 31, 0, 0, 0);
        step;
        chk_cnt("t4.refill", 31);
        drive(3'b111, 3'b000, 0, 0, 0, 0);
        chk_gnt("t4.first", 3'b111, 1, 2, 3);
        step;
        for (int c = 0; c < 8; c++) begin
            drive(3'b111, 3'b000, 0, 0, 0, 0);
            step;
        end
        drive(3'b100, 3'b000, 0, 0, 0, 0);
        step;
        chk_cnt("t4.count3", 3);
        drive(3'b111, 3'b000, 0, 0, 0, 0);
        chk_gnt("t4.wrap", 3'b111, 29, 30, 31);
        step;
        chk_cnt("t4.count0", 0);
        // recovery: head<=tail(=1), count full, returns ignored
        drive(3'b111, 3'b111, 50, 51, 52, 1);
        check("t5.bp_gnt", 32'(alloc_gnt), 32'd0);
        step;
        chk_cnt("t5.rec1", 32);
        for (int c = 0; c < 3; c++) begin
            drive(3'b111, 3'b000, 0, 0, 0, 0);
            step;
        end
        drive(3'b100, 3'b000, 0, 0, 0, 0);
        step;
        chk_cnt("t5.count22", 22);
        drive(3'b111, 3'b111, 60, 61, 62, 1);
        check("t5.bp_gnt2", 32'(alloc_gnt), 32'd0);
        step;
        chk_cnt("t5.rec2", 32);
        drive(3'b111, 3'b000, 0, 0, 0, 0);
        chk_gnt("t5.replay", 3'b111, 41, 1, 2);
        step;
        chk_cnt("t5.count29", 29);
        // overflow: returning into a full list sets the sticky error
        drive(3'b000, 3'b000, 0, 0, 0, 1);
        step;
        chk_cnt("t6.full", 32);
        check("t6.err0", 32'(fl_overflow_err), 32'd0);
        drive(3'b000, 3'b001, 0, 0, 5, 0);
        step;
        check("t6.err", 32'(fl_overflow_err), 32'd1);
        chk_cnt("t6.sat", 32);
        drive(3'b000, 3'b000, 0, 0, 0, 0);
        step;
        check("t6.sticky", 32'(fl_overflow_err), 32'd1);
        drive(3'b111, 3'b000, 0, 0, 0, 0);
        chk_gnt("t6.nowrite", 3'b111, 41, 1, 2);
        alloc_req = '0;
        #1;
        reset = 1'b0;
        #1;
        check("t6.async_err", 32'(fl_overflow_err), 32'd0);
        chk_cnt("t6.async_count", 32);
        #2;
        reset = 1'b1;
        step;
        check("t6.err_clr", 32'(fl_overflow_err), 32'd0);
        drive(3'b111, 3'b000, 0, 0, 0, 0);
        chk_gnt("t6.reinit", 3'b111, 32, 33, 34);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
